// File: rtl/dmem_if.sv
// dmem_if: request/response channel between a load/store requester and dmem_responder.
// resp_err exists only when DMEM_ERR_EN is defined.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_w_en;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef DMEM_ERR_EN
    logic        resp_err;
`endif
    modport master (
        output req_valid, req_w_en, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
`ifdef DMEM_ERR_EN
        , input resp_err
`endif
    );
    modport slave (
        input  req_valid, req_w_en, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
`ifdef DMEM_ERR_EN
        , output resp_err
`endif
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word memory with byte writes and fixed response latency.
// Define DMEM_ERR_EN to flag misaligned or out-of-range addresses on resp_err.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int LAT = (LATENCY < 1) ? 1 : LATENCY;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state, next;
    logic [3:0]        cnt;
    logic [31:0]       rdata;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              accept, bad;
    assign idx            = bus.req_addr[ADDR_W+1:2];
    assign accept         = state == IDLE && bus.req_valid;
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata;
`ifdef DMEM_ERR_EN
    logic err;
    assign bad = bus.req_addr[1:0] != 2'b00 || (bus.req_addr >> (ADDR_W + 2)) != 32'h0;
    assign bus.resp_err = err;
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if (accept) err <= bad;
`else
    logic unused_addr;
    assign bad = 1'b0;
    assign unused_addr = ^{bus.req_addr[1:0], bus.req_addr[31:ADDR_W+2]};
`endif
    always_comb begin
        next = state;
        if (accept) next = (LAT == 1) ? RESP : WAIT;
        else if (state == WAIT && cnt == 4'd0) next = RESP;
        else if (state == RESP && bus.resp_ready) next = IDLE;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'h0;
        end else begin
            state <= next;
            if (accept) begin
                rdata <= bad ? 32'h0 : mem[idx];
                cnt   <= 4'(LAT > 1 ? LAT - 2 : 0);
            end else if (state == WAIT) cnt <= cnt - 4'd1;
        end
    // Read above sees the pre-write word because both use the same edge.
    always_ff @(posedge clk)
        if (!rst && accept && !bad)
            for (int i = 0; i < 4; i++)
                if (bus.req_w_en[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU load/store port: accepts one word request at a time over a valid/ready channel and returns read data or a write acknowledge after a fixed, configurable latency.
- Backed by an internal word-addressed array with per-byte write enables.
- Replaces the zero-latency SRAM model so the core and future pipeline stages can be exercised against realistic memory timing.

Parameters:
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W words of 32 bits.
- LATENCY, 2, cycles from request accept edge to first cycle of resp_valid; legal range 1..15; 0 is treated as 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_w_en  input  4  byte write enables; bit i writes byte i (bits 8i+7:8i); 4'b0000 means read.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  input  32  store data, byte-lane aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  word contents at accept time, before any write; for writes this is the prior contents.

Behaviour:
- Reset values:
  - state IDLE; req_ready=1 from the first cycle after reset.
  - resp_valid=0; resp_rdata=32'h0; latency counter=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: accept the request; capture array[idx] into the response register; commit the byte-masked write on the same edge.
  - Go to RESP if LATENCY==1; otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata stable; req_ready=0.
  - Held until an edge with resp_ready=1, then go to IDLE.
- Timing:
  - With accept at edge T, resp_valid is first high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - Minimum request-to-request spacing is LATENCY+1 cycles with resp_ready held high.
- One outstanding transaction only. Requests arriving while not in IDLE are ignored; the requester holds req_valid and all request fields stable until req_ready.
- req_valid and resp_ready are not sampled outside IDLE and RESP respectively.
- Address bits above ADDR_W+1 are ignored (address aliasing). req_addr[1:0] is ignored unless DMEM_ERR_EN is defined.
- Partial writes leave unmasked bytes unchanged.
- Reset in WAIT or RESP:
  - Returns to IDLE and drops the response: resp_valid=0 next cycle.
  - A write committed at acceptance remains in the array.
- Simultaneous reset and req_valid: reset wins; no access occurs.

Optional Feature:
- Macro DMEM_ERR_EN.
- Defined:
  - Adds output resp_err (1 bit, reset 0), valid with resp_valid.
  - resp_err=1 when req_addr[1:0]!=0, or when req_addr[31:ADDR_W+2]!=0.
  - On error the write is suppressed and resp_rdata=32'h0.
- Not defined:
  - No resp_err port.
  - Low address bits are ignored and upper bits alias, as described above.

Test Plan:
- Reset, LATENCY=2: write addr 0x10, w_en 4'b1111, data 32'hDEADBEEF, accepted at edge T -> req_ready low after T; resp_valid high exactly 2 cycles after T; one-cycle handshake with resp_ready=1; req_ready=1 the following cycle.
- Read addr 0x10 -> resp_rdata=32'hDEADBEEF. Then write w_en 4'b0010, data 32'h0000AA00; read again -> 32'hDEADAAEF.
- Backpressure: after a read response appears, hold resp_ready=0 for 3 cycles -> resp_valid and resp_rdata stable; req_ready=0; a new req_valid is not accepted until one cycle after the resp handshake.
- Reset mid-operation: accept a write 32'h12345678 to addr 0x20 with LATENCY=4, assert rst in WAIT -> resp_valid=0 and req_ready=1 after reset; a subsequent read of 0x20 returns 32'h12345678.
- LATENCY=1 sweep: back-to-back reads of addr 0x0/0x4/0x8 with resp_ready tied 1 -> each response 1 cycle after accept; accepts every 2 cycles.
- DMEM_ERR_EN: write addr 0x22 (misaligned), data 32'hFFFFFFFF -> resp_err=1, resp_rdata=0; read addr 0x20 -> original data, resp_err=0.
